// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates execute (A) and load (B) writebacks onto the single register-file write port.
// Ports:
//   clock, reset                         rising-edge clock, asynchronous active-high reset
//   a_valid/a_ready/a_index/a_data       execute writeback request and accept
//   b_valid/b_ready/b_index/b_data       load writeback request and accept
//   reserve_valid/reserve_index          marks a newly issued load's destination as busy
//   q1_index/q1_busy, q2_index/q2_busy   combinational scoreboard queries
//   enable_write_rd/rd_index/rd          registered register-file write port
module regfile_write_arbiter #(
   parameter int REG_COUNT = 32,
   parameter int XLEN      = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [4:0]      a_index,
   input  logic [XLEN-1:0] a_data,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [4:0]      b_index,
   input  logic [XLEN-1:0] b_data,
   input  logic            reserve_valid,
   input  logic [4:0]      reserve_index,
   input  logic [4:0]      q1_index,
   input  logic [4:0]      q2_index,
   output logic            q1_busy,
   output logic            q2_busy,
   output logic            enable_write_rd,
   output logic [4:0]      rd_index,
   output logic [XLEN-1:0] rd
);
   // Bits that can ever be busy: existing registers other than x0.
   localparam logic [31:0] reg_mask =
      (REG_COUNT >= 32 ? 32'hFFFF_FFFF : (32'd1 << REG_COUNT) - 32'd1) & ~32'd1;
   logic            prio_b;
   logic            out_from_b;
   logic            grant;
   logic [4:0]      win_index;
   logic [XLEN-1:0] win_data;
   logic [31:0]     busy;
   logic [31:0]     set_mask;
   logic [31:0]     clr_mask;
   assign a_ready   = a_valid & (~b_valid | ~prio_b);
   assign b_ready   = b_valid & (~a_valid | prio_b);
   assign grant     = a_ready | b_ready;
   assign win_index = b_ready ? b_index : a_index;
   assign win_data  = b_ready ? b_data : a_data;
   // Clear retires the load write currently on the output; set is applied after, so set wins.
   assign set_mask  = {31'd0, reserve_valid} << reserve_index;
   assign clr_mask  = {31'd0, enable_write_rd & out_from_b} << rd_index;
   assign q1_busy   = busy[q1_index];
   assign q2_busy   = busy[q2_index];
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prio_b          <= 1'b1;
         enable_write_rd <= 1'b0;
         out_from_b      <= 1'b0;
         rd_index        <= 5'd0;
         rd              <= '0;
         busy            <= 32'd0;
      end else begin
         if (a_valid & b_valid) prio_b <= ~prio_b;
         // x0 writes complete the handshake but never reach the register file.
         enable_write_rd <= grant & (win_index != 5'd0);
         out_from_b      <= b_ready;
         if (grant) begin
            rd_index <= win_index;
            rd       <= win_data;
         end
         busy <= ((busy & ~clr_mask) | set_mask) & reg_mask;
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and randomized check of regfile_write_arbiter against a behavioural model.
module tb_regfile_write_arbiter;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        a_valid = 1'b0, b_valid = 1'b0, reserve_valid = 1'b0;
   logic        a_ready, b_ready, q1_busy, q2_busy, enable_write_rd;
   logic [4:0]  a_index = 5'd0, b_index = 5'd0, reserve_index = 5'd0;
   logic [4:0]  q1_index = 5'd0, q2_index = 5'd0, rd_index;
   logic [31:0] a_data = 32'd0, b_data = 32'd0, rd;
   int tests = 0;
   int fails = 0;
   // Reference model state: who wins the next conflict, the pending register-file write, and the
   // set of registers with an outstanding load.
   bit          m_pref_b;
   bit          m_en;
   bit [4:0]    m_idx;
   bit [31:0]   m_data;
   bit          m_from_b;
   bit          m_busy[32];
   bit          m_ga, m_gb;
   regfile_write_arbiter dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_index(a_index), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_index(b_index), .b_data(b_data),
      .reserve_valid(reserve_valid), .reserve_index(reserve_index),
      .q1_index(q1_index), .q2_index(q2_index), .q1_busy(q1_busy), .q2_busy(q2_busy),
      .enable_write_rd(enable_write_rd), .rd_index(rd_index), .rd(rd)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      m_pref_b = 1'b1;
      m_en     = 1'b0;
      m_idx    = 5'd0;
      m_data   = 32'd0;
      m_from_b = 1'b0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
   endtask
   // One clock cycle; call right after a rising edge.
   task automatic step(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bi, input logic [31:0] bd,
                       input logic rv, input logic [4:0] ri);
      bit ga, gb;
      bit nb[32];
      #1;
      a_valid = av; a_index = ai; a_data = ad;
      b_valid = bv; b_index = bi; b_data = bd;
      reserve_valid = rv; reserve_index = ri;
      q1_index = (ai == ri) ? 5'($urandom) : ai;
      q2_index = 5'($urandom);
      @(negedge clock);
      ga = av && (!bv || !m_pref_b);
      gb = bv && (!av || m_pref_b);
      check("a_ready", a_ready, ga);
      check("b_ready", b_ready, gb);
      check("enable_write_rd", enable_write_rd, m_en);
      if (m_en) begin
         check("rd_index", rd_index, m_idx);
         check("rd", rd, m_data);
      end
      check("q1_busy", q1_busy, m_busy[q1_index]);
      check("q2_busy", q2_busy, m_busy[q2_index]);
      nb = m_busy;
      if (m_en && m_from_b) nb[m_idx] = 1'b0;
      if (rv && ri != 5'd0) nb[ri] = 1'b1;
      @(posedge clock);
      m_busy = nb;
      if (ga || gb) begin
         m_idx    = gb ? bi : ai;
         m_data   = gb ? bd : ad;
         m_en     = (m_idx != 5'd0);
         m_from_b = gb;
      end else m_en = 1'b0;
      if (av && bv) m_pref_b = !m_pref_b;
      m_ga = ga;
      m_gb = gb;
   endtask
   initial begin
      logic       pav, pbv;
      logic [4:0] pai, pbi;
      logic [31:0] pad, pbd;
      model_reset();
      #12;
      check("rst_en", enable_write_rd, 1'b0);
      check("rst_rd_index", rd_index, 5'd0);
      check("rst_rd", rd, 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      step(1, 5, 32'h1234, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
      repeat (4) step(1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 9);
      step(1, 9, 32'h99, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 9, 32'h999, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 9);
      step(0, 0, 0, 1, 9, 32'h9A, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 9);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 9, 32'h9B, 0, 0);
      step(0, 0, 0, 1, 0, 32'h5, 0, 0);
      step(1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
      step(0, 0, 0, 1, 0, 32'h6, 0, 0);
      step(1, 1, 32'h33, 1, 2, 32'h44, 0, 0);
      step(1, 0, 32'h7, 1, 6, 32'h66, 0, 0);
      step(1, 1, 32'h55, 1, 2, 32'h77, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      pav = 1'b0; pbv = 1'b0;
      pai = 5'd0; pbi = 5'd0; pad = 32'd0; pbd = 32'd0;
      repeat (1500) begin
         if (!pav) begin
            pav = ($urandom_range(0, 2) != 0);
            pai = 5'($urandom);
            pad = $urandom;
         end
         if (!pbv) begin
            pbv = ($urandom_range(0, 2) != 0);
            pbi = 5'($urandom);
            pbd = $urandom;
         end
         step(pav, pai, pad, pbv, pbi, pbd, $urandom_range(0, 3) == 0, 5'($urandom));
         if (m_ga) pav = 1'b0;
         if (m_gb) pbv = 1'b0;
      end
      step(0, 0, 0, 0, 0, 0, 1, 12);
      step(1, 5, 32'h55, 0, 0, 0, 1, 13);
      #2;
      check("pre_rst_en", enable_write_rd, m_en);
      a_valid = 1'b0; b_valid = 1'b0; reserve_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("async_rst_en", enable_write_rd, 1'b0);
      model_reset();
      for (int i = 0; i < 32; i++) begin
         q1_index = 5'(i);
         #1;
         check("rst_q1_busy", q1_busy, 1'b0);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      step(1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
      step(1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
